// File: rtl/uart_rx_if.sv
// Host-side signal bundle of the UART receiver.
// The 9th-bit signals exist only when UART_RX_9BIT_EN is defined.
interface uart_rx_if;
    logic        uart_en;
    logic [15:0] uart_baud;
    logic        uart_rx;
    logic        uart_rxpnd_clr;
    logic [7:0]  uart_rxbuf;
    logic        uart_rxpnd;
    logic        uart_rx_ferr;
    logic        uart_rx_ovr;
    logic        uart_rx_busy;
`ifdef UART_RX_9BIT_EN
    logic        uart_prty_en;
    logic        uart_rx9;

    modport master (
        output uart_en, uart_baud, uart_rx, uart_rxpnd_clr, uart_prty_en,
        input  uart_rxbuf, uart_rx9, uart_rxpnd, uart_rx_ferr, uart_rx_ovr, uart_rx_busy
    );
    modport slave (
        input  uart_en, uart_baud, uart_rx, uart_rxpnd_clr, uart_prty_en,
        output uart_rxbuf, uart_rx9, uart_rxpnd, uart_rx_ferr, uart_rx_ovr, uart_rx_busy
    );
`else
    modport master (
        output uart_en, uart_baud, uart_rx, uart_rxpnd_clr,
        input  uart_rxbuf, uart_rxpnd, uart_rx_ferr, uart_rx_ovr, uart_rx_busy
    );
    modport slave (
        input  uart_en, uart_baud, uart_rx, uart_rxpnd_clr,
        output uart_rxbuf, uart_rxpnd, uart_rx_ferr, uart_rx_ovr, uart_rx_busy
    );
`endif
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver with pending, frame-error and overrun flags.
// Define UART_RX_9BIT_EN to add the optional 9th data bit (uart_prty_en / uart_rx9).
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic     sys_clk,
    input  logic     sys_rst,
    uart_rx_if.slave bus
);

`ifdef UART_RX_9BIT_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_NINTH, S_STOP} state_e;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_prev_q;
    logic                   rx_s;
    logic [15:0]            tick_cnt_q, tick_cnt_d;
    logic [3:0]             sub_q, sub_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             rxbuf_q;
    logic                   rxpnd_q, ferr_q, ovr_q;
    logic                   tick, start_chk, mid_bit, done, busy;
`ifdef UART_RX_9BIT_EN
    logic                   nine_q, nine_d, rx9_q;
`endif

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign tick      = (tick_cnt_q == bus.uart_baud);
    assign start_chk = tick && (sub_q == 4'd7);
    assign mid_bit   = tick && (sub_q == 4'd15);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.uart_rx};
            rx_prev_q <= rx_s;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (rx_prev_q && !rx_s) state_d = S_START;
            S_START: if (start_chk) state_d = rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_9BIT_EN
            S_DATA:  if (mid_bit && bit_idx_q == 3'd7) state_d = bus.uart_prty_en ? S_NINTH : S_STOP;
            S_NINTH: if (mid_bit) state_d = S_STOP;
`else
            S_DATA:  if (mid_bit && bit_idx_q == 3'd7) state_d = S_STOP;
`endif
            S_STOP:  if (mid_bit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (!bus.uart_en) state_d = S_IDLE;
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
        sub_d      = tick ? sub_q + 4'd1 : sub_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        done       = 1'b0;
`ifdef UART_RX_9BIT_EN
        nine_d     = nine_q;
`endif
        case (state_q)
            S_IDLE: begin
                tick_cnt_d = '0;
                sub_d      = '0;
            end
            // Restart the sub-bit phase at start-bit centre so sub==15 hits each later bit centre.
            S_START: if (start_chk && !rx_s) begin
                sub_d     = '0;
                bit_idx_d = '0;
            end
            S_DATA: if (mid_bit) begin
                shift_d   = {rx_s, shift_q[7:1]};
                bit_idx_d = bit_idx_q + 3'd1;
            end
`ifdef UART_RX_9BIT_EN
            S_NINTH: if (mid_bit) nine_d = rx_s;
`endif
            S_STOP:  done = mid_bit && bus.uart_en;
            default: ;
        endcase
        busy = (state_q != S_IDLE);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tick_cnt_q <= '0;
            sub_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
`ifdef UART_RX_9BIT_EN
            nine_q     <= 1'b0;
`endif
        end else begin
            tick_cnt_q <= tick_cnt_d;
            sub_q      <= sub_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
`ifdef UART_RX_9BIT_EN
            nine_q     <= nine_d;
`endif
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rxbuf_q <= '0;
            rxpnd_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_9BIT_EN
            rx9_q   <= 1'b0;
`endif
        end else begin
            if (bus.uart_rxpnd_clr) begin
                rxpnd_q <= 1'b0;
                ovr_q   <= 1'b0;
            end
            // NOTE: non-blocking, so these later assignments override the clear above.
            if (done) begin
                if (!rxpnd_q || bus.uart_rxpnd_clr) begin
                    rxbuf_q <= shift_q;
                    ferr_q  <= ~rx_s;
                    rxpnd_q <= 1'b1;
`ifdef UART_RX_9BIT_EN
                    rx9_q   <= nine_q;
`endif
                end else begin
                    ovr_q <= 1'b1;
                end
            end
        end
    end

    assign bus.uart_rxbuf   = rxbuf_q;
    assign bus.uart_rxpnd   = rxpnd_q;
    assign bus.uart_rx_ferr = ferr_q;
    assign bus.uart_rx_ovr  = ovr_q;
    assign bus.uart_rx_busy = busy;
`ifdef UART_RX_9BIT_EN
    assign bus.uart_rx9     = rx9_q;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the UART: oversamples the asynchronous `uart_rx` pin at 16x the bit rate, frames start/data/(9th)/stop bits, and deposits the byte into a receive buffer with pending, frame-error and overrun flags. It sits beside the transmit path under the UART top. It shares the `uart_baud` divisor and `uart_en` control. Its `uart_rxpnd` output feeds the top-level interrupt logic (`uart_rxie` gating).

## Interface
- `SYNC_STAGES`, default 2: number of metastability flops on `uart_rx`; legal values are 2 or 3.
- `sys_clk` in 1: the block's single clock.
- `sys_rst` in 1: reset, asynchronous and active-high.
- `uart_en` in 1: receiver enable. When low, the FSM is held in IDLE.
- `uart_baud` in 16: divisor. One oversample tick occurs every `uart_baud`+1 `sys_clk` cycles.
- `uart_prty_en` in 1: 9th-bit enable. This port exists only with `UART_RX_9BIT_EN`.
- `uart_rx` in 1: serial input, asynchronous to `sys_clk`; idles high.
- `uart_rxpnd_clr` in 1: single-cycle pulse that clears `uart_rxpnd` and `uart_rx_ovr`.
- `uart_rxbuf` out 8: last accepted byte.
- `uart_rx9` out 1: last accepted 9th bit. This port exists only with `UART_RX_9BIT_EN`.
- `uart_rxpnd` out 1: frame received, not yet cleared.
- `uart_rx_ferr` out 1: stop bit of the last loaded frame sampled as 0.
- `uart_rx_ovr` out 1: a frame completed while `uart_rxpnd` was already 1. Sticky.
- `uart_rx_busy` out 1: FSM is not in IDLE.

## Operation
- **Reset values:**
  - Synchronizer flops: 1.
  - `uart_rxbuf` = 0x00, `uart_rx9` = 0.
  - `uart_rxpnd`, `uart_rx_ferr`, `uart_rx_ovr`, `uart_rx_busy` = 0.
  - FSM = IDLE; tick counter and sub-bit counter = 0.
- **Tick counter (16 bit):**
  - Counts 0..`uart_baud`, then wraps to 0; `tick` is high on the wrap cycle.
  - Forced to 0 in IDLE and on entry to START.
- **Sub-bit counter (4 bit):**
  - Increments on `tick` and wraps from 15 to 0.
  - Forced to 0 in IDLE and on entry to START.
- **FSM:**
  - IDLE -> START: on a falling edge of the synchronized rx (previous 1, current 0) while `uart_en`=1.
  - START -> DATA: on `tick` with sub==7, if rx=0. Clear the bit index.
  - START -> IDLE: on `tick` with sub==7, if rx=1. This is glitch rejection; no flags change.
  - DATA: on `tick` with sub==15, sample rx into the shift register MSB and shift right, so the byte arrives LSB first. After the 8th bit, go to NINTH if enabled, otherwise STOP.
  - NINTH: on `tick` with sub==15, capture rx into a 9th-bit register, then go to STOP.
  - STOP: on `tick` with sub==15, sample rx, perform the load action below, then go to IDLE. The FSM returns to IDLE at mid-stop-bit so the next start edge can be caught immediately.
- **Load action (completion cycle):**
  - If `uart_rxpnd`=0 or `uart_rxpnd_clr`=1:
    - Write the shift register to `uart_rxbuf` and the 9th bit to `uart_rx9`.
    - Set `uart_rx_ferr` to the inverse of the stop sample.
    - Set `uart_rxpnd`=1.
  - Otherwise `uart_rxbuf`, `uart_rx9` and `uart_rx_ferr` are unchanged and `uart_rx_ovr` is set to 1.
- **Simultaneous events:** when `uart_rxpnd_clr` coincides with completion, completion wins: `uart_rxpnd`=1, no overrun, data loaded. `uart_rxpnd_clr` alone clears `uart_rxpnd` and `uart_rx_ovr`; `uart_rx_ferr` is unchanged.
- **Disable mid-frame:** `uart_en`=0 returns the FSM to IDLE on the next clock. The partial frame is discarded. Buffers and flags are retained.
- **Reset mid-frame:** all state returns to reset values asynchronously. No partial load occurs.

## Timing
- Bit period is 16 × (`uart_baud`+1) clocks. `uart_baud`=0 is legal and gives a 16-clock bit.
- Data, 9th and stop bits are sampled at nominal bit centre (8 ticks after the start-edge detect, then every 16 ticks).
- Pin to detect: the falling edge on `uart_rx` enters START `SYNC_STAGES`+1 clocks later.
- Pin to pending, with B = `uart_baud`, `uart_rxpnd` rises:
  - 8-bit frame: within [152·(B+1)+`SYNC_STAGES`, 152·(B+1)+`SYNC_STAGES`+3] clocks after the pin edge.
  - 9-bit frame: add 16·(B+1).
- Registered outputs:
  - `uart_rx_busy` falls in the same clock that `uart_rxpnd` rises.
  - All outputs are registered; none depends combinationally on `uart_rx`.
- `uart_baud` changed mid-frame takes effect at the next tick wrap; the bench does not check such a frame.

## Configuration
- `UART_RX_9BIT_EN` defined:
  - `uart_prty_en` and `uart_rx9` exist.
  - When `uart_prty_en`=1, the frame carries 9 bits and the NINTH state is used.
- `UART_RX_9BIT_EN` not defined:
  - The ports, the NINTH state and the 9th-bit register are removed.
  - Frames are always 8N1.

## Test plan
- **Basic frame:** `uart_baud`=0, send 0xA5 with stop=1. Expect `uart_rxbuf`=0xA5, `uart_rxpnd`=1 at ~154–157 clocks, `uart_rx_ferr`=0.
- **Glitch rejection:** `uart_baud`=3, drive `uart_rx` low for 20 clocks then high. Expect `uart_rx_busy` to pulse and return to 0; `uart_rxpnd` stays 0 and `uart_rxbuf` is unchanged.
- **Frame error:** send 0x3C with stop=0. Expect `uart_rxbuf`=0x3C, `uart_rx_ferr`=1, `uart_rxpnd`=1.
- **Overrun and clear:**
  - Send 0x11, then 0x22, with no clear in between. Expect `uart_rxbuf`=0x11 and `uart_rx_ovr`=1.
  - Pulse `uart_rxpnd_clr`. Expect `uart_rxpnd`=0 and `uart_rx_ovr`=0.
  - Clear in the same clock that 0x33 completes. Expect `uart_rxbuf`=0x33, `uart_rxpnd`=1, `uart_rx_ovr`=0.
- **9th bit (macro on):** `uart_prty_en`=1, send 0x5A with 9th bit=1. Expect `uart_rx9`=1, `uart_rxbuf`=0x5A, `uart_rxpnd` one bit period later than the 8-bit case.
- **Abort:** assert `sys_rst` during data bit 4, or drop `uart_en`. Expect all flags at reset/retained values with no load. A following 0xC3 frame is received correctly.
